// File: rtl/adder_vector_driver.sv
// Operand generator and result checker for a clocked adder.
// Drives a fixed-then-LFSR vector set, waits LATENCY edges, and compares {carry,sum}.
module adder_vector_driver #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [31:0] SEED        = 32'h1ACE_B00C
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [7:0]       first_fail,
  output logic [7:0]       vec_count
);

  localparam int unsigned EXP_W    = WIDTH + 1;
  localparam logic [2:0]  LAT      = 3'(LATENCY);
  localparam logic [7:0]  LAST_IDX = 8'(NUM_VECTORS - 1);
  localparam logic [31:0] TAPS     = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [7:0]  NO_FAIL  = 8'hFF;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic [EXP_W-1:0] r_exp;
  logic [31:0]      r_lfsr;
  logic [2:0]       r_wait;
  logic [7:0]       r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [7:0]       r_err;
  logic [7:0]       r_ff;
  logic [7:0]       r_vec;

  logic             w_first;
  logic             w_load;
  logic             w_cmp;
  logic             w_finish;
  logic [7:0]       w_idx_nxt;
  logic [31:0]      w_l1;
  logic [31:0]      w_l2;
  logic [WIDTH-1:0] w_va;
  logic [WIDTH-1:0] w_vb;
  logic             w_vcin;
  logic [EXP_W-1:0] w_exp_nxt;
  logic             w_mismatch;
  logic [7:0]       w_err_nxt;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and sequencing strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b0;
    w_load      = 1'b0;
    w_cmp       = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_first     = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (r_wait == LAT) begin
          w_cmp = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_finish    = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_idx_nxt = w_first ? 8'd0 : (r_idx + 8'd1);
  assign w_l1      = lfsr_step(r_lfsr);
  assign w_l2      = lfsr_step(w_l1);

  // Vector 0 exercises a full carry chain, vector 1 is a fixed small sum, the rest come from the LFSR.
  always_comb begin
    w_va   = '0;
    w_vb   = '0;
    w_vcin = 1'b0;
    case (w_idx_nxt)
      8'd0: begin
        w_va   = '1;
        w_vb   = '0;
        w_vcin = 1'b1;
      end
      8'd1: begin
        w_va   = WIDTH'(32'd500);
        w_vb   = WIDTH'(32'd600);
        w_vcin = 1'b0;
      end
      default: begin
        w_va   = WIDTH'(w_l1);
        w_vb   = WIDTH'(w_l2);
        w_vcin = w_l1[31] ^ w_l2[0];
      end
    endcase
  end

  assign w_exp_nxt  = EXP_W'(w_va) + EXP_W'(w_vb) + EXP_W'(w_vcin);
  assign w_mismatch = ({carry, sum} != r_exp);
  assign w_err_nxt  = (w_mismatch && (r_err != 8'hFF)) ? (r_err + 8'd1) : r_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cin  <= 1'b0;
      r_exp  <= '0;
      r_lfsr <= SEED_EFF;
      r_wait <= 3'd0;
      r_idx  <= 8'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= 8'd0;
      r_ff   <= NO_FAIL;
      r_vec  <= 8'd0;
    end else begin
      if (w_load) begin
        r_a    <= w_va;
        r_b    <= w_vb;
        r_cin  <= w_vcin;
        r_exp  <= w_exp_nxt;
        r_idx  <= w_idx_nxt;
        r_wait <= 3'd0;
        if (w_first)
          r_lfsr <= SEED_EFF;
        else if (w_idx_nxt >= 8'd2)
          r_lfsr <= w_l2;
      end else if ((r_state == DRIVE) && !w_cmp) begin
        r_wait <= r_wait + 3'd1;
      end

      if (w_first) begin
        r_err  <= 8'd0;
        r_ff   <= NO_FAIL;
        r_vec  <= 8'd0;
        r_busy <= 1'b1;
        r_done <= 1'b0;
        r_pass <= 1'b0;
      end else if (w_cmp) begin
        r_vec <= r_vec + 8'd1;
        r_err <= w_err_nxt;
        if (w_mismatch && (r_ff == NO_FAIL))
          r_ff <= r_idx;
        if (w_finish) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_pass <= (w_err_nxt == 8'd0);
        end
      end
    end
  end

  assign a          = r_a;
  assign b          = r_b;
  assign cin        = r_cin;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign first_fail = r_ff;
  assign vec_count  = r_vec;

endmodule

// File: tb/tb_adder_vector_driver.sv
// Directed bench for adder_vector_driver: a LATENCY=1 instance with a clocked adder
// model (carry can be stuck at 0) and a LATENCY=0 instance with a combinational adder.
module tb_adder_vector_driver;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        carry;
  } vec_t;

  logic clk;
  logic reset_n;
  logic start1;
  logic start0;
  logic force_c0;

  logic [31:0] a1, b1, sum1, r_sum1;
  logic        cin1, carry1, r_carry1;
  logic        busy1, done1, pass1;
  logic [7:0]  err1, ff1, vec1;

  logic [31:0] a0, b0, sum0;
  logic        cin0, carry0;
  logic        busy0, done0, pass0;
  logic [7:0]  err0, ff0, vec0;

  int total;
  int passed;
  int cyc;

  adder_vector_driver #(.WIDTH(32), .LATENCY(1), .NUM_VECTORS(16), .SEED(32'h1ACE_B00C)) dut1 (
    .clock(clk), .reset_n(reset_n), .start(start1),
    .a(a1), .b(b1), .cin(cin1), .sum(sum1), .carry(carry1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1), .vec_count(vec1)
  );

  adder_vector_driver #(.WIDTH(32), .LATENCY(0), .NUM_VECTORS(4), .SEED(32'h1ACE_B00C)) dut0 (
    .clock(clk), .reset_n(reset_n), .start(start0),
    .a(a0), .b(b0), .cin(cin0), .sum(sum0), .carry(carry0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail(ff0), .vec_count(vec0)
  );

  // One-cycle-latency adder; force_c0 holds its carry at 0.
  always @(posedge clk) {r_carry1, r_sum1} <= {1'b0, a1} + {1'b0, b1} + {32'd0, cin1};
  assign sum1   = r_sum1;
  assign carry1 = force_c0 ? 1'b0 : r_carry1;

  assign {carry0, sum0} = {1'b0, a0} + {1'b0, b0} + {32'd0, cin0};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else
      passed++;
  endtask

  task automatic check_reset1(input string tag);
    check({tag, " a"}, 64'(a1), 64'd0);
    check({tag, " b"}, 64'(b1), 64'd0);
    check({tag, " cin"}, 64'(cin1), 64'd0);
    check({tag, " busy"}, 64'(busy1), 64'd0);
    check({tag, " done"}, 64'(done1), 64'd0);
    check({tag, " pass"}, 64'(pass1), 64'd0);
    check({tag, " err_count"}, 64'(err1), 64'd0);
    check({tag, " first_fail"}, 64'(ff1), 64'hFF);
    check({tag, " vec_count"}, 64'(vec1), 64'd0);
  endtask

  // Called at a negedge; leaves us at the negedge after the start edge.
  task automatic pulse_start1();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_done1(input string name, input int maxc);
    int n;
    n = 0;
    while (!done1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check({name, " done within bound"}, 64'(done1), 64'd1);
  endtask

  vec_t        tbl[5];
  logic [31:0] save_a[16];
  logic [31:0] save_b[16];
  int          t0;

  initial begin
    total    = 0;
    passed   = 0;
    cyc      = 0;
    reset_n  = 1'b0;
    start1   = 1'b0;
    start0   = 1'b0;
    force_c0 = 1'b0;

    tbl[0] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000, cin: 1'b1, sum: 32'h0000_0000, carry: 1'b1};
    tbl[1] = '{a: 32'd500,       b: 32'd600,       cin: 1'b0, sum: 32'd1100,       carry: 1'b0};
    tbl[2] = '{a: 32'h0D67_5806, b: 32'h06B3_AC03, cin: 1'b1, sum: 32'h141B_040A, carry: 1'b0};
    tbl[3] = '{a: 32'h8379_D602, b: 32'h41BC_EB01, cin: 1'b0, sum: 32'hC536_C103, carry: 1'b0};
    tbl[4] = '{a: 32'hA0FE_7583, b: 32'hD05F_3AC2, cin: 1'b1, sum: 32'h715D_B046, carry: 1'b1};

    repeat (3) @(negedge clk);
    check_reset1("reset");
    check("reset dut0 first_fail", 64'(ff0), 64'hFF);
    reset_n = 1'b1;
    @(negedge clk);

    // Run 1: vector table, busy window, final status.
    pulse_start1();
    t0 = cyc;
    for (int k = 0; k < 16; k++) begin
      save_a[k] = a1;
      save_b[k] = b1;
      check($sformatf("run1 busy v%0d", k), 64'(busy1), 64'd1);
      if (k < 5) begin
        check($sformatf("run1 a v%0d", k), 64'(a1), 64'(tbl[k].a));
        check($sformatf("run1 b v%0d", k), 64'(b1), 64'(tbl[k].b));
        check($sformatf("run1 cin v%0d", k), 64'(cin1), 64'(tbl[k].cin));
      end
      @(negedge clk);
      if (k < 5) begin
        check($sformatf("run1 sum v%0d", k), 64'(sum1), 64'(tbl[k].sum));
        check($sformatf("run1 carry v%0d", k), 64'(carry1), 64'(tbl[k].carry));
      end
      if (k == 15) check("run1 done not early", 64'(done1), 64'd0);
      @(negedge clk);
    end
    check("run1 length", 64'(cyc - t0), 64'd32);
    check("run1 done", 64'(done1), 64'd1);
    check("run1 busy low", 64'(busy1), 64'd0);
    check("run1 pass", 64'(pass1), 64'd1);
    check("run1 err_count", 64'(err1), 64'd0);
    check("run1 first_fail", 64'(ff1), 64'hFF);
    check("run1 vec_count", 64'(vec1), 64'd16);
    check("run1 a held", 64'(a1), 64'(save_a[15]));

    // Run 2: restart from DONE, with an ignored start at cycle 10.
    pulse_start1();
    check("run2 done cleared", 64'(done1), 64'd0);
    check("run2 vec_count cleared", 64'(vec1), 64'd0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("run2 a v%0d", k), 64'(a1), 64'(save_a[k]));
      check($sformatf("run2 b v%0d", k), 64'(b1), 64'(save_b[k]));
      if (k == 5) start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
    end
    check("run2 done at 32", 64'(done1), 64'd1);
    check("run2 pass", 64'(pass1), 64'd1);
    check("run2 vec_count", 64'(vec1), 64'd16);

    // Run 3: stuck-at-0 carry must be caught on vector 0.
    force_c0 = 1'b1;
    pulse_start1();
    wait_done1("run3", 100);
    check("run3 pass", 64'(pass1), 64'd0);
    check("run3 first_fail", 64'(ff1), 64'd0);
    check("run3 err_count nonzero", 64'(err1 != 8'd0), 64'd1);
    check("run3 err_count not above vectors", 64'(err1 <= 8'd16), 64'd1);
    force_c0 = 1'b0;
    @(negedge clk);

    // Run 4: asynchronous reset mid-run, then a clean run.
    pulse_start1();
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset1("midrun reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_start1();
    check("run4 a v0", 64'(a1), 64'hFFFF_FFFF);
    wait_done1("run4", 100);
    check("run4 pass", 64'(pass1), 64'd1);
    check("run4 vec_count", 64'(vec1), 64'd16);

    // LATENCY=0 instance, four vectors.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("lat0 busy", 64'(busy0), 64'd1);
    check("lat0 a v0", 64'(a0), 64'hFFFF_FFFF);
    @(negedge clk);
    check("lat0 a v1", 64'(a0), 64'd500);
    repeat (2) @(negedge clk);
    check("lat0 a v3", 64'(a0), 64'h8379_D602);
    check("lat0 done not early", 64'(done0), 64'd0);
    @(negedge clk);
    check("lat0 done", 64'(done0), 64'd1);
    check("lat0 pass", 64'(pass0), 64'd1);
    check("lat0 vec_count", 64'(vec0), 64'd4);
    check("lat0 first_fail", 64'(ff0), 64'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adder_vector_driver.md
Name: adder_vector_driver

Overview:
- Operand-side counterpart of the team's clocked 32-bit adder (ports a, b, cin, clock, sum, carry).
- Generates operand vectors, drives them into the adder, waits the adder latency, then checks sum/carry against an internally computed reference.
- Used as an on-chip self-test source/checker in front of the adder, and as a reusable stimulus block in simulation.

Parameters:
- WIDTH, 32, operand and sum width.
- LATENCY, 1, clock edges between the adder capturing operands and presenting sum/carry. 0 means a combinational adder. Legal range 0..7.
- NUM_VECTORS, 16, vectors per run. Legal range 2..255.
- SEED, 32'h1ACE_B00C, LFSR seed. A value of 0 is replaced by 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle run request.
- a  out  WIDTH  operand A to the adder, registered.
- b  out  WIDTH  operand B to the adder, registered.
- cin  out  1  carry-in to the adder, registered.
- sum  in  WIDTH  adder sum.
- carry  in  1  adder carry-out.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start.
- pass  out  1  valid when done=1. 1 iff err_count==0.
- err_count  out  8  mismatch count, saturates at 255.
- first_fail  out  8  index of the first mismatching vector. 8'hFF if none.
- vec_count  out  8  vectors checked so far in the current run.

Behaviour:
- Reset (asynchronous, reset_n=0) forces:
  - a=0, b=0, cin=0.
  - busy=0, done=0, pass=0.
  - err_count=0, first_fail=8'hFF, vec_count=0.
  - lfsr=SEED, state IDLE.
- Reset asserted mid-run aborts the run immediately. No partial results are retained.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 → at that edge, load vector 0 onto a/b/cin, clear the counters, set busy=1, go to DRIVE.
- DRIVE:
  - A wait counter runs 0..LATENCY and resets when each new vector is applied.
  - At the edge where the counter equals LATENCY, compare {carry,sum} against the expected value exp = a + b + cin, computed WIDTH+1 bits wide and registered when the vector was applied.
  - At that same edge, increment vec_count. On mismatch, increment err_count (saturating) and record first_fail if it is still 8'hFF.
  - At that same edge, apply the next vector, or go to DONE if this was vector NUM_VECTORS-1.
  - Each vector therefore occupies LATENCY+1 cycles. A run lasts NUM_VECTORS*(LATENCY+1) cycles from the start edge.
- Vector set:
  - Vector 0: a=all ones, b=0, cin=1. Exercises full carry propagation.
  - Vector 1: a=500, b=600, cin=0.
  - Vector n≥2: advance the 32-bit Galois LFSR (taps 32'h8020_0003, shift right, XOR taps when LSB=1) once, giving a. Advance it again, giving b. cin = a[31]^b[0]. Both advances happen in the same cycle, so the LFSR moves two steps per vector.
  - For WIDTH<32 use the low WIDTH bits. For WIDTH>32, zero-extend.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - a/b/cin hold the last vector.
  - start=1 → restart exactly as from IDLE: done clears, counters clear, lfsr reloads SEED.
- start while busy=1 is ignored.
- sum/carry are ignored on all edges other than the compare edges.

Test Plan:
- Correct adder, LATENCY=1, NUM_VECTORS=16, start pulse at cycle 0 → busy high for 32 cycles. Then done=1, pass=1, err_count=0, first_fail=8'hFF, vec_count=16.
- Same setup, check the first two vectors → a=32'hFFFF_FFFF, b=0, cin=1, and the adder returns sum=0, carry=1. Two cycles later a=500, b=600, cin=0, and sum=1100, carry=0.
- Adder carry output forced to 0 → vector 0 mismatches, first_fail=0, err_count≥1, pass=0 at done.
- reset_n pulled low 5 cycles into a run → all outputs return to reset values immediately. A new start then completes with pass=1.
- start pulsed again at cycle 10 of a run → ignored, done still at cycle 32. start pulsed in DONE → rerun produces an identical a/b sequence (same SEED).
- LATENCY=0 with a combinational adder, NUM_VECTORS=4 → done after 4 cycles, pass=1.
